// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: op encodings, FSM states, default width.
package shift_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift iteration: moves i_data by i_k bits according to i_op.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned KW   = 6
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [KW-1:0]   i_k,
    input  logic [1:0]      i_op,
    output logic [XLEN-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SLL:  o_data = i_data << i_k;
            OP_SRA:  o_data = $signed(i_data) >>> i_k;
            // Reserved encoding 2'b10 behaves as a logical right shift.
            default: o_data = i_data >> i_k;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: accepts SLL/SRL/SRA requests and shifts up to STEP bits per cycle.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned STEP = 1,
    localparam int unsigned SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_a,
    input  logic [SHW-1:0]  req_shamt,
    input  logic [1:0]      req_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    localparam logic [SHW:0] STEP_W = STEP[SHW:0];

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] r_result;
    logic [SHW-1:0]  r_rem;
    logic [1:0]      r_op;
    logic [SHW:0]    w_k;
    logic [SHW:0]    w_rem_next;
    logic [XLEN-1:0] w_shifted;
    logic            w_accept;
    logic            w_last;

    // One extra bit so k can hold STEP == XLEN.
    assign w_k        = ({1'b0, r_rem} > STEP_W) ? STEP_W : {1'b0, r_rem};
    assign w_rem_next = {1'b0, r_rem} - w_k;
    assign w_last     = (w_rem_next == '0);
    assign w_accept   = req_valid && req_ready;

    shift_step #(
        .XLEN (XLEN),
        .KW   (SHW + 1)
    ) u_shift_step (
        .i_data (r_data),
        .i_k    (w_k),
        .i_op   (r_op),
        .o_data (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (req_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE) && !rst;
        rsp_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    assign rsp_result = r_result;

    // r_result is only written on entry to DONE so it holds through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_rem    <= '0;
            r_op     <= OP_SLL;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data <= req_a;
                        r_rem  <= req_shamt;
                        r_op   <= req_op;
                        if (req_shamt == '0) begin
                            r_result <= req_a;
                        end
                    end
                end
                SHIFT: begin
                    r_data <= w_shifted;
                    r_rem  <= w_rem_next[SHW-1:0];
                    if (w_last) begin
                        r_result <= w_shifted;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
